// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
//   Shares the single GMII transmit path between the ARP and UDP frame
//   sources. One requester at a time is granted through a req/gnt handshake.
//   The owner's byte stream is registered onto gmii_tx_en/gmii_txd, an
//   inter-frame gap is forced after every frame or aborted grant, and stalled
//   or runaway owners are cut off with an err_timeout pulse.
//
// Ports
//   gmii_tx_clk  : 125 MHz transmit clock, rising edge
//   sys_rst      : asynchronous active-high reset
//   arp_req      : ARP source wants the path (level)
//   arp_tx_en    : ARP byte valid
//   arp_txd      : ARP byte
//   arp_gnt      : ARP owns the path
//   arp_done     : one-cycle pulse, ARP frame finished normally
//   udp_*        : same meanings for the UDP source
//   gmii_tx_en   : byte valid toward the converter
//   gmii_txd     : byte toward the converter (0 whenever gmii_tx_en is 0)
//   busy         : arbiter is not idle
//   err_timeout  : one-cycle pulse on start timeout or frame-length abort
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; arbitrate pending requests (round-robin on a tie)
// GRANT  | gnt given; waiting for the owner's first tx_en or a withdrawal
// SEND   | forwarding the owner's bytes, counting frame length
// IFG    | forced idle gap on the wire before the next arbitration

module eth_tx_arbiter #(
  parameter int IFG_CYCLES       = 12,
  parameter int START_TIMEOUT    = 64,
  parameter int MAX_FRAME_CYCLES = 1600
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst,
  input  logic       arp_req,
  input  logic       arp_tx_en,
  input  logic [7:0] arp_txd,
  output logic       arp_gnt,
  output logic       arp_done,
  input  logic       udp_req,
  input  logic       udp_tx_en,
  input  logic [7:0] udp_txd,
  output logic       udp_gnt,
  output logic       udp_done,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_IFG   = 2'd3
  } state_t;

  localparam logic       OWN_ARP  = 1'b0;
  localparam logic       OWN_UDP  = 1'b1;
  localparam logic [10:0] START_TC = 11'(START_TIMEOUT - 1);
  localparam logic [10:0] FRAME_TC = 11'(MAX_FRAME_CYCLES);
  localparam logic [10:0] IFG_TC   = 11'(IFG_CYCLES - 1);

  state_t      state;
  logic        owner;
  logic        last_owner;
  logic [10:0] cnt;

  logic        own_req;
  logic        own_tx_en;
  logic [7:0]  own_txd;
  logic        any_req;
  logic        pick;
  logic [10:0] cnt_sat;

  // Only the current owner's signals are ever looked at outside IDLE, which
  // keeps the non-owner's stream off the wire.
  assign own_req   = (owner == OWN_UDP) ? udp_req   : arp_req;
  assign own_tx_en = (owner == OWN_UDP) ? udp_tx_en : arp_tx_en;
  assign own_txd   = (owner == OWN_UDP) ? udp_txd   : arp_txd;

  assign any_req = arp_req | udp_req;
  // On a tie the source that did not own the path last time wins.
  assign pick    = (arp_req && udp_req) ? ~last_owner : udp_req;

  // Counter saturates at all-ones instead of wrapping.
  assign cnt_sat = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;

  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      owner       <= OWN_ARP;
      last_owner  <= OWN_UDP;
      cnt         <= '0;
      arp_gnt     <= 1'b0;
      udp_gnt     <= 1'b0;
      arp_done    <= 1'b0;
      udp_done    <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= '0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // Pulses and the data path default low; SEND re-asserts them per byte.
      arp_done    <= 1'b0;
      udp_done    <= 1'b0;
      err_timeout <= 1'b0;
      gmii_tx_en  <= 1'b0;
      gmii_txd    <= '0;

      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner      <= pick;
            last_owner <= pick;
            arp_gnt    <= (pick == OWN_ARP);
            udp_gnt    <= (pick == OWN_UDP);
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (own_tx_en) begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= own_txd;
            cnt        <= 11'd1;
            state      <= ST_SEND;
          end else if (!own_req) begin
            // Withdrawal: nothing went on the wire, so no gap is needed.
            arp_gnt <= 1'b0;
            udp_gnt <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt >= START_TC) begin
            arp_gnt     <= 1'b0;
            udp_gnt     <= 1'b0;
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= ST_IFG;
          end else begin
            cnt <= cnt_sat;
          end
        end

        ST_SEND: begin
          if (!own_tx_en) begin
            arp_gnt  <= 1'b0;
            udp_gnt  <= 1'b0;
            arp_done <= (owner == OWN_ARP);
            udp_done <= (owner == OWN_UDP);
            cnt      <= '0;
            state    <= ST_IFG;
          end else if (cnt >= FRAME_TC) begin
            // Runaway frame: truncate it; the owner gets no done.
            arp_gnt     <= 1'b0;
            udp_gnt     <= 1'b0;
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= ST_IFG;
          end else begin
            gmii_tx_en <= 1'b1;
            gmii_txd   <= own_txd;
            cnt        <= cnt_sat;
          end
        end

        ST_IFG: begin
          if (cnt >= IFG_TC) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_sat;
          end
        end

        default: begin
          arp_gnt <= 1'b0;
          udp_gnt <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
//   Self-checking bench for eth_tx_arbiter. Bytes expected on the wire are
//   queued when the owner drives them and popped by a monitor as they appear
//   on gmii_txd. A table of arbitration vectors covers grant decisions, and
//   hand-written sequences cover the tie/round-robin, timeouts, isolation,
//   withdrawal and mid-frame reset.
//
// Ports: none (top-level bench).

module tb_eth_tx_arbiter;

  logic       gmii_tx_clk = 1'b0;
  logic       sys_rst;
  logic       arp_req, arp_tx_en;
  logic [7:0] arp_txd;
  logic       arp_gnt, arp_done;
  logic       udp_req, udp_tx_en;
  logic [7:0] udp_txd;
  logic       udp_gnt, udp_done;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       busy, err_timeout;

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  eth_tx_arbiter dut (
    .gmii_tx_clk (gmii_tx_clk),
    .sys_rst     (sys_rst),
    .arp_req     (arp_req),
    .arp_tx_en   (arp_tx_en),
    .arp_txd     (arp_txd),
    .arp_gnt     (arp_gnt),
    .arp_done    (arp_done),
    .udp_req     (udp_req),
    .udp_tx_en   (udp_tx_en),
    .udp_txd     (udp_txd),
    .udp_gnt     (udp_gnt),
    .udp_done    (udp_done),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  bit         grant_log[$];
  int         n_arp_done = 0, n_udp_done = 0, n_err_to = 0, n_aa = 0;
  int         gap = 0, min_gap = 1000000;
  bit         seen_frame = 1'b0;
  logic       p_arp_gnt = 1'b0, p_udp_gnt = 1'b0, p_en = 1'b0;
  logic [7:0] mon_b;

  typedef struct {
    bit arp_r;
    bit udp_r;
    int nb;
    int base;
    bit exp_udp;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge gmii_tx_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input bit src, input logic en, input logic [7:0] d);
    if (src) begin
      udp_tx_en = en;
      udp_txd   = d;
    end else begin
      arp_tx_en = en;
      arp_txd   = d;
    end
  endtask

  task automatic set_req(input bit src, input logic r);
    if (src) udp_req = r;
    else     arp_req = r;
  endtask

  task automatic wait_gnt(input int budget, output bit got, output bit who);
    got = 1'b0;
    who = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (arp_gnt || udp_gnt) begin
        got = 1'b1;
        who = udp_gnt;
        break;
      end
    end
  endtask

  // Drives nb bytes from src starting one cycle after the grant. The first
  // nfwd bytes are expected on the wire. An abort drops the source's req.
  task automatic send_frame(input bit src, input int nb, input int base, input int nfwd,
                            input bit check_end, output int abort_idx);
    abort_idx = -1;
    for (int i = 0; i < nb; i++) begin
      set_src(src, 1'b1, 8'(base + i));
      if (i < nfwd) exp_q.push_back(8'(base + i));
      tick();
      if (err_timeout && abort_idx < 0) begin
        abort_idx = i;
        set_req(src, 1'b0);
        chk("abort_gnt_drop", src ? udp_gnt : arp_gnt, 0);
        chk("abort_wire_low", gmii_tx_en, 0);
      end
    end
    set_src(src, 1'b0, 8'h00);
    if (check_end) begin
      tick();
      chk("eof_done", src ? udp_done : arp_done, 1);
      chk("eof_gnt", src ? udp_gnt : arp_gnt, 0);
      chk("eof_wire", gmii_tx_en, 0);
      tick();
      chk("eof_done_low", src ? udp_done : arp_done, 0);
    end
  endtask

  // Wire monitor and event counters.
  initial begin
    forever begin
      @(negedge gmii_tx_clk);
      if (!sys_rst) begin
        n_cmp++;
        if (!gmii_tx_en && gmii_txd != 8'h00) begin
          n_err++;
          $display("FAIL txd_idle_zero: gmii_txd=%02h, required 00", gmii_txd);
        end
        if (gmii_tx_en) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_byte: gmii_txd=%02h, required no byte", gmii_txd);
          end else begin
            mon_b = exp_q.pop_front();
            if (gmii_txd != mon_b) begin
              n_err++;
              $display("FAIL wire_byte: gmii_txd=%02h, required %02h", gmii_txd, mon_b);
            end
          end
          if (gmii_txd == 8'hAA) n_aa++;
          if (!p_en && seen_frame && gap < min_gap) min_gap = gap;
          gap = 0;
          seen_frame = 1'b1;
        end else begin
          gap++;
        end
        n_cmp++;
        if (arp_gnt && udp_gnt) begin
          n_err++;
          $display("FAIL gnt_exclusive: arp_gnt=%0b udp_gnt=%0b, required one-hot", arp_gnt, udp_gnt);
        end
        if (arp_gnt && !p_arp_gnt) grant_log.push_back(1'b0);
        if (udp_gnt && !p_udp_gnt) grant_log.push_back(1'b1);
        if (arp_done) n_arp_done++;
        if (udp_done) n_udp_done++;
        if (err_timeout) n_err_to++;
      end
      p_arp_gnt = arp_gnt;
      p_udp_gnt = udp_gnt;
      p_en      = gmii_tx_en;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, who;
    int ai, ai2, hi, k2, n_log, na, nu, e0, d0, a0;

    tbl[0] = '{1'b1, 1'b0, 60, 'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 30, 'h80, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 16, 'h40, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 16, 'h50, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 8,  'h60, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8,  'h70, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1,  'hF0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 5,  'hC0, 1'b1};

    sys_rst   = 1'b1;
    arp_req   = 1'b1;
    udp_req   = 1'b1;
    arp_tx_en = 1'b0;
    arp_txd   = 8'h00;
    udp_tx_en = 1'b0;
    udp_txd   = 8'h00;
    repeat (3) tick();
    chk("rst_arp_gnt", arp_gnt, 0);
    chk("rst_udp_gnt", udp_gnt, 0);
    chk("rst_arp_done", arp_done, 0);
    chk("rst_udp_done", udp_done, 0);
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_txd", gmii_txd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    sys_rst = 1'b0;

    // Tie from reset, both re-request continuously: ARP, UDP, ARP, UDP.
    for (int f = 0; f < 4; f++) begin
      wait_gnt(40, got, who);
      chk("rr_got_gnt", got, 1);
      if (!got) break;
      chk("rr_order", who, f % 2);
      send_frame(who, 64, f * 16, 64, 1'b1, ai);
    end
    arp_req = 1'b0;
    udp_req = 1'b0;
    chk("rr_log_size", grant_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) chk("rr_log", grant_log[k], k % 2);
    n_cmp++;
    if (min_gap < 12) begin
      n_err++;
      $display("FAIL rr_ifg_gap: got %0d idle cycles, required at least 12", min_gap);
    end
    repeat (14) tick();
    chk("rr_idle", busy, 0);

    // Table of single-frame arbitrations.
    for (int e = 0; e < 8; e++) begin
      arp_req = tbl[e].arp_r;
      udp_req = tbl[e].udp_r;
      n_log = grant_log.size();
      na = n_arp_done;
      nu = n_udp_done;
      tick();
      chk("tbl_arp_gnt", arp_gnt, !tbl[e].exp_udp);
      chk("tbl_udp_gnt", udp_gnt, tbl[e].exp_udp);
      chk("tbl_busy", busy, 1);
      send_frame(tbl[e].exp_udp, tbl[e].nb, tbl[e].base, tbl[e].nb, 1'b1, ai);
      arp_req = 1'b0;
      udp_req = 1'b0;
      repeat (14) tick();
      chk("tbl_idle", busy, 0);
      chk("tbl_one_grant", grant_log.size() - n_log, 1);
      chk("tbl_arp_done_cnt", n_arp_done - na, tbl[e].exp_udp ? 0 : 1);
      chk("tbl_udp_done_cnt", n_udp_done - nu, tbl[e].exp_udp ? 1 : 0);
    end

    // Start timeout with a pending ARP request.
    udp_req = 1'b1;
    tick();
    chk("to_udp_gnt", udp_gnt, 1);
    arp_req = 1'b1;
    e0 = n_err_to;
    d0 = n_udp_done;
    hi = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!udp_gnt) break;
      hi++;
    end
    chk("to_gnt_cycles", hi, 64);
    chk("to_err_pulse", err_timeout, 1);
    udp_req = 1'b0;
    k2 = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      k2++;
      if (arp_gnt) begin
        got = 1'b1;
        break;
      end
    end
    chk("to_arp_got", got, 1);
    chk("to_arp_after_ifg", k2, 13);
    chk("to_err_count", n_err_to - e0, 1);
    chk("to_no_udp_done", n_udp_done - d0, 0);
    arp_req = 1'b0;
    tick();
    chk("to_arp_withdraw", arp_gnt, 0);
    chk("to_idle", busy, 0);

    // Runaway ARP frame.
    arp_req = 1'b1;
    tick();
    chk("run_arp_gnt", arp_gnt, 1);
    e0 = n_err_to;
    d0 = n_arp_done;
    send_frame(1'b0, 2000, 0, 1600, 1'b0, ai);
    chk("run_abort_idx", ai, 1600);
    repeat (14) tick();
    chk("run_idle", busy, 0);
    chk("run_err_count", n_err_to - e0, 1);
    chk("run_no_done", n_arp_done - d0, 0);

    // Isolation: ARP toggles 0xAA while UDP owns the path.
    udp_req = 1'b1;
    tick();
    chk("iso_udp_gnt", udp_gnt, 1);
    a0 = n_aa;
    fork
      send_frame(1'b1, 40, 'h10, 40, 1'b1, ai2);
      begin
        for (int k = 0; k < 45; k++) begin
          arp_txd   = 8'hAA;
          arp_tx_en = k[0];
          tick();
        end
        arp_tx_en = 1'b0;
        arp_txd   = 8'h00;
      end
    join
    udp_req = 1'b0;
    chk("iso_no_aa", n_aa - a0, 0);
    repeat (14) tick();
    chk("iso_idle", busy, 0);

    // Withdrawal in GRANT.
    udp_req = 1'b1;
    tick();
    chk("wd_udp_gnt", udp_gnt, 1);
    e0 = n_err_to;
    d0 = n_udp_done;
    udp_req = 1'b0;
    tick();
    chk("wd_gnt_drop", udp_gnt, 0);
    chk("wd_idle", busy, 0);
    chk("wd_no_done", udp_done, 0);
    chk("wd_no_err", err_timeout, 0);
    arp_req = 1'b1;
    tick();
    chk("wd_no_gap", arp_gnt, 1);
    arp_req = 1'b0;
    tick();
    chk("wd_idle2", busy, 0);
    chk("wd_err_count", n_err_to - e0, 0);
    chk("wd_done_count", n_udp_done - d0, 0);

    // Reset at byte 20 of an ARP frame (ARP owned last, so only the reset
    // value of last_owner lets ARP win the following tie).
    arp_req = 1'b1;
    tick();
    chk("mr_arp_gnt", arp_gnt, 1);
    for (int i = 0; i < 20; i++) begin
      set_src(1'b0, 1'b1, 8'(i + 1));
      exp_q.push_back(8'(i + 1));
      tick();
    end
    set_src(1'b0, 1'b1, 8'd21);
    #2;
    chk("mr_pre_tx_en", gmii_tx_en, 1);
    sys_rst = 1'b1;
    #1;
    chk("mr_tx_en", gmii_tx_en, 0);
    chk("mr_txd", gmii_txd, 0);
    chk("mr_arp_gnt_clr", arp_gnt, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", err_timeout, 0);
    chk("mr_done", arp_done, 0);
    exp_q.delete();
    set_src(1'b0, 1'b0, 8'h00);
    udp_req = 1'b1;
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    chk("mr_tie_arp", arp_gnt, 1);
    chk("mr_tie_udp", udp_gnt, 0);
    arp_req = 1'b0;
    udp_req = 1'b0;
    repeat (20) tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Shares the single GMII transmit path (into the SGMII/GMII converter) between two frame sources: the ARP transmitter and the UDP transmitter. It grants the path to one requester at a time using a request/grant handshake. It multiplexes the owner's byte stream onto `gmii_tx_en`/`gmii_txd`, enforces the Ethernet inter-frame gap, and recovers from requesters that stall. It sits between the `arp`/UDP TX engines and `sgmii_to_gmii`, in the `gmii_tx_clk` domain.

## Interface
Parameters:
- `IFG_CYCLES`, 12: idle cycles forced after every frame or aborted grant.
- `START_TIMEOUT`, 64: cycles the owner has to raise its `tx_en` after grant.
- `MAX_FRAME_CYCLES`, 1600: maximum `tx_en`-high cycles per frame before a forced abort.

Ports:
- `gmii_tx_clk` in 1: 125 MHz clock; all logic runs on its rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `arp_req` in 1: ARP source wants the path; level, held until `arp_done` or withdrawn.
- `arp_tx_en` in 1: ARP byte valid.
- `arp_txd` in 8: ARP byte.
- `arp_gnt` out 1: ARP owns the path.
- `arp_done` out 1: 1-cycle pulse, ARP frame finished.
- `udp_req`, `udp_tx_en`, `udp_txd[7:0]`, `udp_gnt`, `udp_done`: same meanings for the UDP source.
- `gmii_tx_en` out 1: to the converter.
- `gmii_txd` out 8: to the converter.
- `busy` out 1: high in any state other than IDLE.
- `err_timeout` out 1: 1-cycle pulse on a start timeout or a frame-length abort.

## Operation
- FSM states: IDLE, GRANT, SEND, IFG. Reset state is IDLE.
- Reset values: all outputs 0; internal `last_owner` = UDP, so ARP wins the first tie.
- IDLE:
  - If exactly one `req` is high, grant that source.
  - If both are high, grant the source that is not `last_owner` (round-robin).
  - On grant: set that `gnt`, update `last_owner`, clear the counter, go to GRANT.
- GRANT:
  - If the owner's `tx_en` is sampled 1: copy the owner's `tx_en`/`txd` to the gmii outputs, go to SEND.
  - Else if the owner's `req` is sampled 0 (withdrawn): drop `gnt`, go to IDLE. No `done`, no gap.
  - Else if the counter reaches `START_TIMEOUT`-1: drop `gnt`, pulse `err_timeout`, go to IFG.
- SEND:
  - Each cycle the gmii outputs register the owner's `tx_en`/`txd`, and the frame counter increments.
  - When the owner's `tx_en` is sampled 0: `gmii_tx_en` goes 0, `gnt` goes 0, the owner's `done` pulses, go to IFG.
  - When the frame counter reaches `MAX_FRAME_CYCLES`: force `gmii_tx_en` to 0, drop `gnt`, pulse `err_timeout`, go to IFG. No `done`.
- IFG: `gmii_tx_en` stays 0 for `IFG_CYCLES` cycles, then go to IDLE.
- Isolation:
  - The non-owner's `tx_en`/`txd` never reach the gmii outputs.
  - `gmii_txd` is 0 whenever `gmii_tx_en` is 0.
  - Requests arriving during GRANT, SEND or IFG are held pending and arbitrated on return to IDLE.
- Counters are 11 bits wide and saturate; no wrap-around.
- The owner dropping `req` during SEND is ignored; the frame ends only by `tx_en` falling or by abort.
- `sys_rst` asserted mid-frame: all outputs clear asynchronously. The converter sees a truncated frame; this is acceptable.

## Timing
- Grant latency: `req` sampled high at edge N gives `gnt` = 1 after edge N.
- Data latency is 1 cycle: the owner's byte at edge M appears on `gmii_txd`/`gmii_tx_en` after edge M.
- End of frame: owner `tx_en` sampled 0 at edge E. After edge E, `gmii_tx_en` = 0, `gnt` = 0 and `done` = 1 (low again after E+1).
- Back-to-back frames: the earliest next `gnt` is after edge E+`IFG_CYCLES`+1, giving at least 12 idle cycles on the wire.
- Start timeout: `gnt` high for exactly `START_TIMEOUT` cycles, then `err_timeout` pulses together with `gnt` falling.
- No combinational path from any input to any output.

## Test plan
- Single ARP frame: `arp_req`=1, then a 60-byte `tx_en` burst (0x00..0x3B) one cycle after grant. Required: the identical 60 bytes on `gmii_txd` delayed 1 cycle; one `arp_done` pulse; `udp_gnt` stays 0.
- Tie and round-robin: both `req` high from reset, each sends 64 bytes, both re-request immediately. Required grant order ARP, UDP, ARP, UDP; at least 12 cycles of `gmii_tx_en`=0 between frames.
- Start timeout: `udp_req`=1 and `udp_tx_en` never raised. Required: `udp_gnt` high for 64 cycles, one `err_timeout` pulse, no `udp_done`; a pending `arp_req` is granted after the 12-cycle IFG.
- Runaway frame: `arp_tx_en` held high for 2000 cycles. Required: `gmii_tx_en` forced low after 1600 cycles, `err_timeout` pulse, `arp_gnt` dropped, remaining ARP bytes not forwarded.
- Isolation and withdrawal: UDP owns the path while `arp_tx_en` toggles with `arp_txd`=0xAA. Required: 0xAA never appears on `gmii_txd`. Separately, `udp_req` drops in GRANT: required immediate return to IDLE, no `done`, no `err_timeout`.
- Reset mid-frame: assert `sys_rst` at byte 20 of a frame. Required: all outputs 0 immediately; after release, the first tie is won by ARP.
